rop3_feeder: RTL and testbench



---
 rtl/rop3_feeder.sv | 166 ++++++++++++++++
 tb/tb_rop3_feeder.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rop3_feeder.sv
// rop3_feeder
// Upstream stage of the ROP3 engine. Whole requests (P, S, D bitmaps plus an
// 8-bit mode) arrive over a valid/ready handshake and are buffered in a small
// FIFO. Each buffered request is then serialised onto the engine's single
// Bitmap bus as P, S, D over three consecutive cycles, with Mode held for the
// whole frame and phase carrying the engine's load-state code.
//
// Parameters:
//   N      bitmap width
//   DEPTH  FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   hold              (only with ROP3_FEEDER_HOLD_EN) blocks new frames
//   req_valid/ready   request handshake; ready = FIFO not full
//   req_P/S/D, req_mode  request payload
//   Bitmap, Mode      registered serialised bitmap and frame mode
//   phase             registered phase code: 0 idle, 1 P, 2 S, 3 D
//   fifo_count        entries currently buffered
//
// Optional feature: define ROP3_FEEDER_HOLD_EN to add the hold input.

module rop3_feeder #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef ROP3_FEEDER_HOLD_EN
  input  logic                   hold,
`endif
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [N-1:0]           req_P,
  input  logic [N-1:0]           req_S,
  input  logic [N-1:0]           req_D,
  input  logic [7:0]             req_mode,
  output logic [N-1:0]           Bitmap,
  output logic [7:0]             Mode,
  output logic [1:0]             phase,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 3 * N + 8;

  // State encoding doubles as the phase code seen by the engine.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_P = 2'd1,
    SEND_S = 2'd2,
    SEND_D = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [EW-1:0]   entry_d;
  logic [EW-1:0]   frame_q, frame_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [N-1:0]    bitmap_q, bitmap_d;
  logic [7:0]      mode_q, mode_d;
  logic            hold_w;
  logic            push;
  logic            pop;
  logic            start;

`ifdef ROP3_FEEDER_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  // Ready only depends on the registered count, so a pop in the same cycle
  // never lets a request slip into a full FIFO.
  assign req_ready  = (count_q < CW'(DEPTH));
  assign push       = req_valid && req_ready;
  assign entry_d    = {req_P, req_S, req_D, req_mode};

  assign Bitmap     = bitmap_q;
  assign Mode       = mode_q;
  assign phase      = state_q;
  assign fifo_count = count_q;

  // Next-state logic: a frame may only start from IDLE or straight after the
  // D cycle of the previous frame; starting a frame is what pops the FIFO.
  // Output registers are loaded from the state being entered, so Bitmap and
  // Mode line up with phase in the cycle after the transition edge.
  always_comb begin
    start    = (count_q != '0) && !hold_w;
    state_d  = state_q;
    pop      = 1'b0;
    case (state_q)
      IDLE:    if (start) begin
                 state_d = SEND_P;
                 pop     = 1'b1;
               end
      SEND_P:  state_d = SEND_S;
      SEND_S:  state_d = SEND_D;
      SEND_D:  if (start) begin
                 state_d = SEND_P;
                 pop     = 1'b1;
               end else begin
                 state_d = IDLE;
               end
      default: state_d = IDLE;
    endcase

    frame_d  = pop ? mem_q[rd_ptr_q] : frame_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    bitmap_d = '0;
    mode_d   = '0;
    case (state_d)
      SEND_P:  begin
                 bitmap_d = frame_d[EW-1 -: N];
                 mode_d   = frame_d[7:0];
               end
      SEND_S:  begin
                 bitmap_d = frame_d[EW-1-N -: N];
                 mode_d   = frame_d[7:0];
               end
      SEND_D:  begin
                 bitmap_d = frame_d[EW-1-2*N -: N];
                 mode_d   = frame_d[7:0];
               end
      default: begin
                 bitmap_d = '0;
                 mode_d   = '0;
               end
    endcase
  end

  // All state, including the FIFO storage, is cleared by reset so that a
  // reset mid-frame drops both the partial frame and any buffered entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      bitmap_q <= '0;
      mode_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      bitmap_q <= bitmap_d;
      mode_q   <= mode_d;
      if (push) begin
        mem_q[wr_ptr_q] <= entry_d;
      end
    end
  end

endmodule

// File: tb/tb_rop3_feeder.sv
// tb_rop3_feeder
// Directed bench for rop3_feeder: reset, single frame, back-to-back frames,
// FIFO full/wrap ordering, asynchronous reset mid-frame and (when
// ROP3_FEEDER_HOLD_EN is defined) the hold input.

module tb_rop3_feeder;

  localparam int N     = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
`ifdef ROP3_FEEDER_HOLD_EN
  logic         hold;
`endif
  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] req_P;
  logic [N-1:0] req_S;
  logic [N-1:0] req_D;
  logic [7:0]   req_mode;
  logic [N-1:0] Bitmap;
  logic [7:0]   Mode;
  logic [1:0]   phase;
  logic [2:0]   fifo_count;

  int tests = 0;
  int fails = 0;

  rop3_feeder #(.N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef ROP3_FEEDER_HOLD_EN
    .hold       (hold),
`endif
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_P      (req_P),
    .req_S      (req_S),
    .req_D      (req_D),
    .req_mode   (req_mode),
    .Bitmap     (Bitmap),
    .Mode       (Mode),
    .phase      (phase),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Present one request on the input bus (taken at the next rising edge).
  task automatic drive_req(input logic [7:0] p, input logic [7:0] s,
                           input logic [7:0] d, input logic [7:0] m);
    req_valid = 1'b1;
    req_P     = p;
    req_S     = s;
    req_D     = d;
    req_mode  = m;
  endtask

  task automatic drive_idle();
    req_valid = 1'b0;
    req_P     = '0;
    req_S     = '0;
    req_D     = '0;
    req_mode  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    #12;
    tests++;
    if ({phase, Bitmap, Mode, fifo_count} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs got phase=%0d Bitmap=%h Mode=%h count=%0d expected all 0",
               phase, Bitmap, Mode, fifo_count);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_ready got %b expected 1", req_ready);
    end
    tests++;
    if (phase !== 2'd0 || fifo_count !== 3'd0) begin
      fails++;
      $display("[TB] FAIL reset_idle got phase=%0d count=%0d expected 0/0", phase, fifo_count);
    end
  endtask

  task automatic test_single();
    logic [1:0] ep [4];
    logic [7:0] eb [4];
    logic [7:0] em [4];
    ep = '{2'd1, 2'd2, 2'd3, 2'd0};
    eb = '{8'hA5, 8'h3C, 8'h0F, 8'h00};
    em = '{8'h5A, 8'h5A, 8'h5A, 8'h00};
    @(negedge clk);
    drive_req(8'hA5, 8'h3C, 8'h0F, 8'h5A);
    @(negedge clk);
    drive_idle();
    tests++;
    if (fifo_count !== 3'd1 || phase !== 2'd0) begin
      fails++;
      $display("[TB] FAIL single_push got count=%0d phase=%0d expected 1/0", fifo_count, phase);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (phase !== ep[i] || Bitmap !== eb[i] || Mode !== em[i]) begin
        fails++;
        $display("[TB] FAIL single[%0d] got phase=%0d Bitmap=%h Mode=%h expected %0d/%h/%h",
                 i, phase, Bitmap, Mode, ep[i], eb[i], em[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ep [7];
    logic [7:0] eb [7];
    logic [7:0] em [7];
    ep = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0};
    eb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00};
    em = '{8'h88, 8'h88, 8'h88, 8'hEE, 8'hEE, 8'hEE, 8'h00};
    @(negedge clk);
    drive_req(8'h11, 8'h22, 8'h33, 8'h88);
    @(negedge clk);
    drive_req(8'h44, 8'h55, 8'h66, 8'hEE);
    @(negedge clk);
    drive_idle();
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (phase !== ep[i] || Bitmap !== eb[i] || Mode !== em[i]) begin
        fails++;
        $display("[TB] FAIL b2b[%0d] got phase=%0d Bitmap=%h Mode=%h expected %0d/%h/%h",
                 i, phase, Bitmap, Mode, ep[i], eb[i], em[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_full();
    logic [7:0] vp [6];
    logic [7:0] vs [6];
    logic [7:0] vd [6];
    logic [7:0] vm [6];
    logic [7:0] exp_b;
    int in_idx  = 0;
    int out_idx = 0;
    int sub     = 0;
    int max_cnt = 0;
    bit done    = 1'b0;
    bit will_push;
    for (int i = 0; i < 6; i++) begin
      vp[i] = 8'(8'h10 + i);
      vs[i] = 8'(8'h20 + i);
      vd[i] = 8'(8'h30 + i);
      vm[i] = 8'(8'hC0 + i);
    end
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      @(negedge clk);
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (fifo_count == 3'd4) begin
        tests++;
        if (req_ready !== 1'b0) begin
          fails++;
          $display("[TB] FAIL full_ready cyc=%0d got %b expected 0", cyc, req_ready);
        end
      end
      if (phase != 2'd0) begin
        tests++;
        if (out_idx > 5) begin
          fails++;
          $display("[TB] FAIL full_extra got phase=%0d Bitmap=%h expected idle", phase, Bitmap);
        end else begin
          exp_b = (sub == 0) ? vp[out_idx] : (sub == 1) ? vs[out_idx] : vd[out_idx];
          if (phase !== 2'(sub + 1) || Bitmap !== exp_b || Mode !== vm[out_idx]) begin
            fails++;
            $display("[TB] FAIL full_out[%0d.%0d] got phase=%0d Bitmap=%h Mode=%h expected %0d/%h/%h",
                     out_idx, sub, phase, Bitmap, Mode, sub + 1, exp_b, vm[out_idx]);
          end
        end
        sub++;
        if (sub == 3) begin
          sub = 0;
          out_idx++;
        end
      end else begin
        if (sub != 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL full_gap got phase=0 expected phase=%0d", sub + 1);
          sub = 0;
        end
        if (out_idx >= 6 && in_idx == 6) done = 1'b1;
      end
      if (in_idx < 6) drive_req(vp[in_idx], vs[in_idx], vd[in_idx], vm[in_idx]);
      else            drive_idle();
      will_push = req_valid && req_ready;
      @(posedge clk);
      if (will_push) in_idx++;
    end
    drive_idle();
    tests++;
    if (done !== 1'b1 || out_idx != 6) begin
      fails++;
      $display("[TB] FAIL full_complete got frames=%0d accepted=%0d expected 6/6", out_idx, in_idx);
    end
    tests++;
    if (max_cnt != 4) begin
      fails++;
      $display("[TB] FAIL full_max_count got %0d expected 4", max_cnt);
    end
    tests++;
    if (fifo_count !== 3'd0) begin
      fails++;
      $display("[TB] FAIL full_drained got count=%0d expected 0", fifo_count);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_req(8'h01, 8'h02, 8'h03, 8'h44);
    @(negedge clk);
    drive_req(8'h05, 8'h06, 8'h07, 8'h55);
    @(negedge clk);
    drive_req(8'h09, 8'h0A, 8'h0B, 8'h66);
    @(negedge clk);
    drive_idle();
    tests++;
    if (phase !== 2'd2 || fifo_count !== 3'd2 || Bitmap !== 8'h02) begin
      fails++;
      $display("[TB] FAIL rstmid_pre got phase=%0d count=%0d Bitmap=%h expected 2/2/02",
               phase, fifo_count, Bitmap);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({phase, Bitmap, Mode, fifo_count} !== '0) begin
      fails++;
      $display("[TB] FAIL rstmid_async got phase=%0d Bitmap=%h Mode=%h count=%0d expected all 0",
               phase, Bitmap, Mode, fifo_count);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if ({phase, Bitmap, Mode, fifo_count} !== '0 || req_ready !== 1'b1) begin
        fails++;
        $display("[TB] FAIL rstmid_after[%0d] got phase=%0d Bitmap=%h count=%0d ready=%b expected 0/00/0/1",
                 i, phase, Bitmap, fifo_count, req_ready);
      end
    end
  endtask

`ifdef ROP3_FEEDER_HOLD_EN
  task automatic test_hold();
    logic [1:0] ep [4];
    logic [7:0] eb [4];
    @(negedge clk);
    drive_req(8'hA1, 8'hB1, 8'hC1, 8'h11);
    @(negedge clk);
    drive_req(8'hA2, 8'hB2, 8'hC2, 8'h22);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    tests++;
    if (phase !== 2'd2 || fifo_count !== 3'd1) begin
      fails++;
      $display("[TB] FAIL hold_pre got phase=%0d count=%0d expected 2/1", phase, fifo_count);
    end
    hold = 1'b1;
    @(negedge clk);
    tests++;
    if (phase !== 2'd3 || Bitmap !== 8'hC1 || Mode !== 8'h11) begin
      fails++;
      $display("[TB] FAIL hold_finish got phase=%0d Bitmap=%h Mode=%h expected 3/C1/11", phase, Bitmap, Mode);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (phase !== 2'd0 || Bitmap !== 8'h00 || fifo_count !== 3'd1) begin
        fails++;
        $display("[TB] FAIL hold_idle[%0d] got phase=%0d Bitmap=%h count=%0d expected 0/00/1",
                 i, phase, Bitmap, fifo_count);
      end
    end
    hold = 1'b0;
    ep = '{2'd1, 2'd2, 2'd3, 2'd0};
    eb = '{8'hA2, 8'hB2, 8'hC2, 8'h00};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (phase !== ep[i] || Bitmap !== eb[i]) begin
        fails++;
        $display("[TB] FAIL hold_resume[%0d] got phase=%0d Bitmap=%h expected %0d/%h",
                 i, phase, Bitmap, ep[i], eb[i]);
      end
    end
  endtask
`endif

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
`ifdef ROP3_FEEDER_HOLD_EN
    hold = 1'b0;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_reset_mid();
`ifdef ROP3_FEEDER_HOLD_EN
    test_hold();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
